// File: rtl/adder_arb.sv
// adder_arb: round-robin arbiter sharing one ripple-carry adder
// between four requesters; two cycles from grant to registered result.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   req[3:0]        per-requester request
//   a_bus, b_bus    operands, requester i at [i*N +: N]
//   cin[3:0]        per-requester carry-in
//   lock[3:0]       carry-chain lock (used only with ADDER_ARB_LOCK_EN)
//   gnt[3:0]        one-hot grant pulse, operands captured
//   sum, cout       registered result
//   vld             one-cycle result-valid pulse
//   vld_id          requester that owns the result
//
// Option: define ADDER_ARB_LOCK_EN to let a requester chain
// back-to-back words through the carry (multi-word adds).
module adder_arb #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req,
  input  logic [4*N-1:0] a_bus,
  input  logic [4*N-1:0] b_bus,
  input  logic [3:0]     cin,
  input  logic [3:0]     lock,
  output logic [3:0]     gnt,
  output logic [N-1:0]   sum,
  output logic           cout,
  output logic           vld,
  output logic [1:0]     vld_id
);

  typedef enum logic {
    IDLE,
    EXEC
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [1:0]   ptr;
  logic [1:0]   id;
  logic [1:0]   base;
  logic [1:0]   win;
  logic         any;
  logic         c_sel;
  logic         load;
  logic         done;

  logic [N-1:0] opa;
  logic [N-1:0] opb;
  logic         opc;

  logic [N-1:0] s_c;
  logic         co_c;

`ifdef ADDER_ARB_LOCK_EN
  logic chain;
  logic chain_c;
  logic take;
  logic drop;
`else
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  // Winner search. The loop runs from the farthest offset down
  // so the nearest set bit from base overwrites the others.
  always_comb begin
    base = ptr;
`ifdef ADDER_ARB_LOCK_EN
    take = chain && req[id];
    drop = chain && !req[id];
    // An abandoned chain resumes round-robin after its owner.
    if (drop)
      base = id + 2'd1;
`endif
    win = base;
    any = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[base + 2'(k)]) begin
        win = base + 2'(k);
        any = 1'b1;
      end
    end
    c_sel = cin[win];
`ifdef ADDER_ARB_LOCK_EN
    if (take) begin
      win   = id;
      any   = 1'b1;
      c_sel = chain_c;
    end
`endif
  end

  // Bitwise ripple-carry adder on the latched operands.
  always_comb begin
    logic c;
    s_c = '0;
    c   = opc;
    for (int i = 0; i < N; i++) begin
      s_c[i] = opa[i] ^ opb[i] ^ c;
      c = (opa[i] & opb[i]) |
          (opa[i] & c) |
          (opb[i] & c);
    end
    co_c = c;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) begin
          state_nxt = EXEC;
          load      = 1'b1;
        end
      end
      EXEC: begin
        state_nxt = IDLE;
        done      = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt    <= '0;
      vld    <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      vld_id <= '0;
      ptr    <= '0;
      id     <= '0;
      opa    <= '0;
      opb    <= '0;
      opc    <= 1'b0;
    end else begin
      gnt <= load ? (4'b0001 << win) : 4'b0000;
      vld <= done;
      if (load) begin
        opa <= a_bus[win*N +: N];
        opb <= b_bus[win*N +: N];
        opc <= c_sel;
        id  <= win;
      end
`ifdef ADDER_ARB_LOCK_EN
      if (drop && state == IDLE)
        ptr <= id + 2'd1;
`endif
      if (done) begin
        sum    <= s_c;
        cout   <= co_c;
        vld_id <= id;
`ifdef ADDER_ARB_LOCK_EN
        ptr    <= lock[id] ? id : id + 2'd1;
`else
        ptr    <= id + 2'd1;
`endif
      end
    end
  end

`ifdef ADDER_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain   <= 1'b0;
      chain_c <= 1'b0;
    end else if (done) begin
      chain   <= lock[id];
      chain_c <= co_c;
    end else if (drop && state == IDLE) begin
      chain   <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_adder_arb.sv
// tb_adder_arb: directed checks of adder_arb arbitration,
// arithmetic, reset abort and (optionally) carry chaining.
module tb_adder_arb;

  localparam int N = 8;

  logic           clk;
  logic           rst_n;
  logic [3:0]     req;
  logic [4*N-1:0] a_bus;
  logic [4*N-1:0] b_bus;
  logic [3:0]     cin;
  logic [3:0]     lock;
  logic [3:0]     gnt;
  logic [N-1:0]   sum;
  logic           cout;
  logic           vld;
  logic [1:0]     vld_id;

  int errors;
  int checks;

  adder_arb #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .a_bus  (a_bus),
    .b_bus  (b_bus),
    .cin    (cin),
    .lock   (lock),
    .gnt    (gnt),
    .sum    (sum),
    .cout   (cout),
    .vld    (vld),
    .vld_id (vld_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic setop(input int i,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input logic c);
    a_bus[i*N +: N] = a;
    b_bus[i*N +: N] = b;
    cin[i] = c;
  endtask

  // Expected order and results for the held 4'b1111 phase.
  logic [3:0] rr_gnt [5];
  logic [7:0] rr_sum [5];
  logic       rr_co  [5];
  logic [1:0] rr_id  [5];

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    req    = '0;
    a_bus  = '0;
    b_bus  = '0;
    cin    = '0;
    lock   = '0;

    rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_sum = '{8'h13, 8'h24, 8'h37, 8'h34, 8'h13};
    rr_co  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rr_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    repeat (3) cyc();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_vld", 32'(vld), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_id", 32'(vld_id), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("idle_gnt", 32'(gnt), 0);

    // Single requester 0: 3C + 0F + 1 = 4C
    setop(0, 8'h3C, 8'h0F, 1'b1);
    req = 4'b0001;
    cyc();
    chk("t1_gnt", 32'(gnt), 32'b0001);
    chk("t1_vld0", 32'(vld), 0);
    req = 4'b0000;
    cyc();
    chk("t1_vld", 32'(vld), 1);
    chk("t1_sum", 32'(sum), 32'h4C);
    chk("t1_cout", 32'(cout), 0);
    chk("t1_id", 32'(vld_id), 0);
    chk("t1_gnt0", 32'(gnt), 0);
    cyc();
    chk("t1_vldpulse", 32'(vld), 0);
    chk("t1_hold", 32'(sum), 32'h4C);

    // Overflow through requester 1: FF + 01 = 00, carry
    setop(1, 8'hFF, 8'h01, 1'b0);
    req = 4'b0010;
    cyc();
    chk("t2_gnt", 32'(gnt), 32'b0010);
    req = 4'b0000;
    cyc();
    chk("t2_sum", 32'(sum), 32'h00);
    chk("t2_cout", 32'(cout), 1);
    chk("t2_id", 32'(vld_id), 1);

    // Pointer at 2, req 0011: 0 wins first, then 1
    setop(0, 8'hFF, 8'hFF, 1'b1);
    req = 4'b0011;
    cyc();
    chk("t3_gnt0", 32'(gnt), 32'b0001);
    req = 4'b0010;
    cyc();
    chk("t3_sum0", 32'(sum), 32'hFF);
    chk("t3_cout0", 32'(cout), 1);
    chk("t3_id0", 32'(vld_id), 0);
    cyc();
    chk("t3_gnt1", 32'(gnt), 32'b0010);
    req = 4'b0000;
    cyc();
    chk("t3_id1", 32'(vld_id), 1);
    chk("t3_sum1", 32'(sum), 32'h00);

    // Pointer now 2; abort an op for requester 2 with reset
    setop(2, 8'h33, 8'h03, 1'b1);
    req = 4'b0100;
    cyc();
    chk("t4_gnt", 32'(gnt), 32'b0100);
    req = 4'b0000;
    rst_n = 1'b0;
    #1;
    chk("t4_gnt_r", 32'(gnt), 0);
    chk("t4_sum_r", 32'(sum), 0);
    chk("t4_cout_r", 32'(cout), 0);
    chk("t4_id_r", 32'(vld_id), 0);
    cyc();
    chk("t4_vld_r", 32'(vld), 0);

    // Release with all four requesting: ptr back at 0
    setop(0, 8'h11, 8'h01, 1'b1);
    setop(1, 8'h22, 8'h02, 1'b0);
    setop(2, 8'h33, 8'h03, 1'b1);
    setop(3, 8'h44, 8'hF0, 1'b0);
    req = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("rr%0d_gnt", i), 32'(gnt), 32'(rr_gnt[i]));
      chk($sformatf("rr%0d_vld0", i), 32'(vld), 0);
      cyc();
      chk($sformatf("rr%0d_vld", i), 32'(vld), 1);
      chk($sformatf("rr%0d_id", i), 32'(vld_id), 32'(rr_id[i]));
      chk($sformatf("rr%0d_sum", i), 32'(sum), 32'(rr_sum[i]));
      chk($sformatf("rr%0d_co", i), 32'(cout), 32'(rr_co[i]));
      chk($sformatf("rr%0d_gnt0", i), 32'(gnt), 0);
    end
    req = 4'b0000;
    cyc();

`ifdef ADDER_ARB_LOCK_EN
    // Two-word add on requester 2: FF+01 then 00+00+carry
    setop(2, 8'hFF, 8'h01, 1'b0);
    lock = 4'b0100;
    req  = 4'b0100;
    cyc();
    chk("lk_gnt0", 32'(gnt), 32'b0100);
    cyc();
    chk("lk_sum0", 32'(sum), 32'h00);
    chk("lk_co0", 32'(cout), 1);
    setop(2, 8'h00, 8'h00, 1'b0);
    lock = 4'b0000;
    req  = 4'b1111;
    cyc();
    chk("lk_gnt1", 32'(gnt), 32'b0100);
    req = 4'b0000;
    cyc();
    chk("lk_sum1", 32'(sum), 32'h01);
    chk("lk_co1", 32'(cout), 0);
    chk("lk_id1", 32'(vld_id), 2);
    cyc();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
